sht10_meas_scheduler: RTL
=========================

Name: sht10_meas_scheduler

Overview:
Periodic measurement sequencer for the SHT10 sensor path. It counts the one-second tick pulses and, every `period` seconds, runs one measurement cycle: a temperature measurement, then a humidity measurement, on the sensor interface through a start/busy/done handshake. It holds the last good raw results, flags NACKs and timeouts, and sits between the 1 s tick generator and the SHT10 serial interface.

Parameters:
PERIOD_W, 4, width of the `period` input.
TIMEOUT_TICKS, 2, number of ticks allowed while waiting for `meas_done` before a cycle is aborted (minimum 1).
DATA_W, 16, raw measurement width.

Ports:
clock  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle pulse, once per second
enable  in  1  1 = run periodic measurements
period  in  PERIOD_W  seconds between cycles; 0 is treated as 1
meas_start  out  1  one-cycle request to the sensor interface
meas_hum  out  1  measurement type: 0 = temperature, 1 = humidity; stable from meas_start until done or abort
meas_busy  in  1  sensor interface busy; no start is issued while high
meas_done  in  1  one-cycle pulse; `meas_data` and `meas_err` are valid with it
meas_err  in  1  sensor NACK/CRC failure, qualified by `meas_done`
meas_data  in  DATA_W  raw result
temp_raw  out  DATA_W  last published temperature
hum_raw  out  DATA_W  last published humidity
update  out  1  one-cycle pulse when `temp_raw` and `hum_raw` change
sensor_err  out  1  last cycle failed (NACK or timeout)
err_count  out  8  failed cycles, saturating at 255
cycle_busy  out  1  high in all states except IDLE and WAIT_PERIOD

Behaviour:
- Reset values: all outputs are 0, state is IDLE, and all internal counters and shadow registers are 0. Every output is registered.
- States: IDLE, WAIT_PERIOD, START_T, WAIT_T, START_H, WAIT_H, PUBLISH.
- IDLE:
  - Stays in IDLE while `enable` = 0.
  - When `enable` = 1: go to WAIT_PERIOD, clear `tick_cnt`, and latch `eff_period` = (`period` == 0 ? 1 : `period`).
- WAIT_PERIOD:
  - If `enable` = 0: go to IDLE.
  - Else on `tick`: `tick_cnt` increments. When `tick_cnt` + 1 == `eff_period`, go to START_T and clear `tick_cnt`.
  - A `period` change takes effect at the next entry to WAIT_PERIOD.
- START_T:
  - Waits while `meas_busy` = 1; ticks do not advance the timeout here.
  - When `meas_busy` = 0: pulse `meas_start` for one cycle with `meas_hum` = 0, clear `to_cnt`, and go to WAIT_T.
- Start latency: with `meas_busy` low, `meas_start` is high exactly 2 cycles after the terminal tick cycle.
- WAIT_T:
  - `meas_done` with `meas_err` = 0: latch `meas_data` into the temperature shadow and go to START_H.
  - `meas_done` with `meas_err` = 1: abort.
  - On `tick`: `to_cnt` increments. When `to_cnt` + 1 == TIMEOUT_TICKS: abort.
  - `meas_done` and the timeout tick in the same cycle: `meas_done` wins.
- START_H / WAIT_H: identical to START_T / WAIT_T with `meas_hum` = 1 and the humidity shadow.
- PUBLISH (one cycle):
  - Copy both shadows to `temp_raw` / `hum_raw`, pulse `update`, clear `sensor_err`.
  - Go to WAIT_PERIOD, re-latching `eff_period`.
- Abort:
  - Set `sensor_err` = 1 and increment `err_count` (saturating).
  - `temp_raw` / `hum_raw` are unchanged; a half cycle is never published.
  - Go to WAIT_PERIOD.
- `meas_done` outside WAIT_T/WAIT_H (including a late done after a timeout) is ignored.
- `enable` deassert during a cycle: the cycle runs to PUBLISH or abort, then WAIT_PERIOD sees `enable` = 0 and goes to IDLE.
- `err_count` is cleared only by reset.
- `tick` in the same cycle as an IDLE→WAIT_PERIOD transition is not counted.
- Reset mid-operation: immediate return to the reset state. A pending `meas_start` is dropped and is not re-issued after reset.

Test Plan:
1. Normal cycle:
   - Stimulus: `period` = 3, `enable` = 1, `tick` every 20 cycles. Sensor model asserts `meas_done` 5 cycles after start with 0x1234 (temperature), then 0x0567 (humidity).
   - Response: starts on every 3rd tick with `meas_hum` 0 then 1; `update` pulses; `temp_raw` = 0x1234, `hum_raw` = 0x0567; `meas_start` exactly 2 cycles after the terminal tick.
2. Zero period:
   - Stimulus: `period` = 0.
   - Response: one measurement cycle per tick.
3. NACK:
   - Stimulus: `meas_err` = 1 on the temperature measurement.
   - Response: no humidity start; `sensor_err` = 1; `err_count` = 1; outputs unchanged, no `update`. The next good cycle clears `sensor_err`, and `err_count` stays 1.
4. Timeout:
   - Stimulus: TIMEOUT_TICKS = 2, sensor never responds.
   - Response: abort on the 2nd tick in WAIT_T. A later `meas_done` is ignored. 300 forced aborts leave `err_count` = 255.
5. Busy hold:
   - Stimulus: `meas_busy` held high for 50 cycles at START_T.
   - Response: `meas_start` is deferred until the cycle after `meas_busy` falls; ticks during the hold cause no timeout.
6. Mid-cycle disruption:
   - `enable` dropped in WAIT_H: the cycle completes, `update` pulses, then IDLE.
   - Reset asserted in WAIT_T: all outputs 0 immediately, and no `meas_start` after release until the period elapses again.

Source files
------------

// File: rtl/sht10_meas_scheduler.sv
// Periodic SHT10 measurement sequencer: every `period` ticks it runs a temperature
// then humidity measurement, publishes both together and tracks failed cycles.
module sht10_meas_scheduler #(
    parameter int PERIOD_W      = 4,
    parameter int TIMEOUT_TICKS = 2,
    parameter int DATA_W        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                meas_start,
    output logic                meas_hum,
    input  logic                meas_busy,
    input  logic                meas_done,
    input  logic                meas_err,
    input  logic [DATA_W-1:0]   meas_data,
    output logic [DATA_W-1:0]   temp_raw,
    output logic [DATA_W-1:0]   hum_raw,
    output logic                update,
    output logic                sensor_err,
    output logic [7:0]          err_count,
    output logic                cycle_busy
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] WAIT_PERIOD = 3'd1;
    localparam logic [2:0] START_T     = 3'd2;
    localparam logic [2:0] WAIT_T      = 3'd3;
    localparam logic [2:0] START_H     = 3'd4;
    localparam logic [2:0] WAIT_H      = 3'd5;
    localparam logic [2:0] PUBLISH     = 3'd6;

    localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [TO_W-1:0]     TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [TO_W-1:0]     TO_ONE  = TO_W'(1);
    localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1);

    logic [2:0]          state, state_nxt;
    logic [PERIOD_W-1:0] tick_cnt;
    logic [PERIOD_W-1:0] eff_period;
    logic [PERIOD_W-1:0] period_eff;
    logic [TO_W-1:0]     to_cnt;
    logic [DATA_W-1:0]   temp_sh;
    logic [DATA_W-1:0]   hum_sh;
    logic                in_wait;
    logic                tick_term;
    logic                done_ok;
    logic                done_bad;
    logic                to_hit;
    logic                abort;

    assign period_eff = (period == '0) ? P_ONE : period;
    assign in_wait    = (state == WAIT_T) || (state == WAIT_H);
    assign tick_term  = tick && (tick_cnt == eff_period - P_ONE);
    assign done_ok    = meas_done && !meas_err;
    assign done_bad   = meas_done && meas_err;
    assign to_hit     = tick && (to_cnt == TO_LAST);
    // A good done outranks a timeout tick landing in the same cycle.
    assign abort      = in_wait && !done_ok && (done_bad || to_hit);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (enable) state_nxt = WAIT_PERIOD;
            WAIT_PERIOD: if (!enable) state_nxt = IDLE;
                         else if (tick_term) state_nxt = START_T;
            START_T:     if (!meas_busy) state_nxt = WAIT_T;
            WAIT_T:      if (done_ok) state_nxt = START_H;
                         else if (abort) state_nxt = WAIT_PERIOD;
            START_H:     if (!meas_busy) state_nxt = WAIT_H;
            WAIT_H:      if (done_ok) state_nxt = PUBLISH;
                         else if (abort) state_nxt = WAIT_PERIOD;
            PUBLISH:     state_nxt = WAIT_PERIOD;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            eff_period <= '0;
            to_cnt     <= '0;
            temp_sh    <= '0;
            hum_sh     <= '0;
            meas_start <= 1'b0;
            meas_hum   <= 1'b0;
            temp_raw   <= '0;
            hum_raw    <= '0;
            update     <= 1'b0;
            sensor_err <= 1'b0;
            err_count  <= '0;
            cycle_busy <= 1'b0;
        end else begin
            state      <= state_nxt;
            meas_start <= 1'b0;
            update     <= 1'b0;
            cycle_busy <= !((state_nxt == IDLE) || (state_nxt == WAIT_PERIOD));

            // Every entry to WAIT_PERIOD restarts the count with the current period.
            if ((state_nxt == WAIT_PERIOD) && (state != WAIT_PERIOD)) begin
                tick_cnt   <= '0;
                eff_period <= period_eff;
            end else if ((state == WAIT_PERIOD) && enable && tick) begin
                tick_cnt <= tick_term ? '0 : tick_cnt + P_ONE;
            end

            case (state)
                START_T, START_H: begin
                    if (!meas_busy) begin
                        meas_start <= 1'b1;
                        meas_hum   <= (state == START_H);
                        to_cnt     <= '0;
                    end
                end
                WAIT_T: begin
                    if (done_ok) temp_sh <= meas_data;
                    else if (tick) to_cnt <= to_cnt + TO_ONE;
                end
                WAIT_H: begin
                    if (done_ok) hum_sh <= meas_data;
                    else if (tick) to_cnt <= to_cnt + TO_ONE;
                end
                PUBLISH: begin
                    temp_raw   <= temp_sh;
                    hum_raw    <= hum_sh;
                    update     <= 1'b1;
                    sensor_err <= 1'b0;
                end
                default: ;
            endcase

            if (abort) begin
                sensor_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
